branch_target_buffer: RTL and testbench

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/branch_target_buffer_pkg.sv | 24 ++
 rtl/branch_target_buffer.sv | 98 +++++++++
 tb/tb_branch_target_buffer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_target_buffer_pkg.sv
// Shared sizing, PC type and entry layout for the direct-mapped branch target buffer.
package branch_target_buffer_pkg;

  typedef logic [31:0] pc_t;

  localparam int BTB_ENTRIES = 64;
  localparam int BTB_INDEX_W = $clog2(BTB_ENTRIES);
  localparam int BTB_TAG_W   = 30 - BTB_INDEX_W;

  // Stored tag is sized for the smallest legal table (4 entries); larger tables zero-fill the top.
  localparam int BTB_TAG_STORE_W = 28;

  typedef struct packed {
    logic                       valid;
    logic [BTB_TAG_STORE_W-1:0] tag;
    logic [29:0]                target;
  } BtbEntry;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } btb_state_e;

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: combinational lookup for fetch, single-cycle update from the memory-access
// stage, and a post-reset sweep that clears every valid bit before predictions are allowed.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES
) (
  input  logic clk,
  input  logic rst,
  input  pc_t  fetchPc,
  output logic hit,
  output pc_t  predictedTarget,
  output logic ready,
  input  pc_t  updPc,
  input  logic updIsBranch,
  input  logic updTaken,
  input  pc_t  updTarget
);

  localparam int            IW       = $clog2(ENTRIES);
  localparam logic [IW-1:0] LAST_IDX = IW'(ENTRIES - 1);

  btb_state_e                 state_q, state_d;
  logic [IW-1:0]              cnt_q, cnt_d;
  BtbEntry                    table_q [ENTRIES];

  logic [IW-1:0]              fetch_idx, upd_idx, vld_idx;
  logic [BTB_TAG_STORE_W-1:0] fetch_tag, upd_tag;
  logic                       vld_we, vld_val, tt_we;
  logic                       unused_pc_bits;

  assign fetch_idx      = fetchPc[IW+1:2];
  assign fetch_tag      = BTB_TAG_STORE_W'(fetchPc[31:IW+2]);
  assign upd_idx        = updPc[IW+1:2];
  assign upd_tag        = BTB_TAG_STORE_W'(updPc[31:IW+2]);
  assign unused_pc_bits = ^{fetchPc[1:0], updPc[1:0], updTarget[1:0]};

  assign ready = (state_q == READY);

  // Lookup reads the registered table, so a same-cycle update is only visible next cycle.
  always_comb begin
    hit             = 1'b0;
    predictedTarget = '0;
    if (ready && table_q[fetch_idx].valid && (table_q[fetch_idx].tag == fetch_tag)) begin
      hit             = 1'b1;
      predictedTarget = {table_q[fetch_idx].target, 2'b00};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vld_we  = 1'b0;
    vld_val = 1'b0;
    vld_idx = cnt_q;
    tt_we   = 1'b0;
    if (state_q == INIT) begin
      vld_we = 1'b1;
      if (cnt_q == LAST_IDX) begin
        state_d = READY;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (updIsBranch) begin
      vld_idx = upd_idx;
      if (updTaken) begin
        vld_we  = 1'b1;
        vld_val = 1'b1;
        tt_we   = 1'b1;
      end else begin
        // A not-taken branch only evicts its own entry, never an alias sharing the index.
        vld_we = (table_q[upd_idx].tag == upd_tag);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Tags and targets are never reset; only the sweep and updates touch valid bits.
  always_ff @(posedge clk) begin
    if (rst && vld_we) begin
      table_q[vld_idx].valid <= vld_val;
    end
    if (rst && tt_we) begin
      table_q[upd_idx].tag    <= upd_tag;
      table_q[upd_idx].target <= updTarget[31:2];
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Randomized and directed bench for branch_target_buffer against a map-based reference model.
module tb_branch_target_buffer;
  import branch_target_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  pc_t  fetchPc = '0;
  pc_t  updPc = '0;
  pc_t  updTarget = '0;
  logic updIsBranch = 1'b0;
  logic updTaken = 1'b0;
  logic hit;
  logic ready;
  pc_t  predictedTarget;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model: installed branch PC and target keyed by table index (pc[7:2]).
  pc_t m_pc  [int];
  pc_t m_tgt [int];
  int  m_cnt = 0;

  always #5 clk = ~clk;

  branch_target_buffer #(.ENTRIES(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetchPc        (fetchPc),
    .hit            (hit),
    .predictedTarget(predictedTarget),
    .ready          (ready),
    .updPc          (updPc),
    .updIsBranch    (updIsBranch),
    .updTaken       (updTaken),
    .updTarget      (updTarget)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: ready after 64 released edges; before that every update is ignored.
  always @(posedge clk) begin : model
    int i;
    i = int'(updPc[7:2]);
    if (!rst) begin
      m_cnt = 0;
      m_pc.delete();
      m_tgt.delete();
    end else if (m_cnt < 64) begin
      m_cnt = m_cnt + 1;
    end else if (updIsBranch) begin
      if (updTaken) begin
        m_pc[i]  = updPc;
        m_tgt[i] = {updTarget[31:2], 2'b00};
      end else if (m_pc.exists(i)) begin
        if (m_pc[i][31:8] == updPc[31:8]) begin
          m_pc.delete(i);
          m_tgt.delete(i);
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    int   i;
    logic e_rdy;
    logic e_hit;
    pc_t  e_tgt;
    if (chk_en) begin
      i     = int'(fetchPc[7:2]);
      e_rdy = (m_cnt == 64);
      e_hit = 1'b0;
      e_tgt = '0;
      if (e_rdy && m_pc.exists(i)) begin
        if (m_pc[i][31:8] == fetchPc[31:8]) begin
          e_hit = 1'b1;
          e_tgt = m_tgt[i];
        end
      end
      chk("cyc_ready", {31'd0, ready}, {31'd0, e_rdy});
      chk("cyc_hit", {31'd0, hit}, {31'd0, e_hit});
      chk("cyc_target", predictedTarget, e_tgt);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input pc_t f, input logic br, input logic tk, input pc_t up, input pc_t ut);
    fetchPc     = f;
    updIsBranch = br;
    updTaken    = tk;
    updPc       = up;
    updTarget   = ut;
  endtask

  task automatic probe(input string nm, input logic eh, input pc_t et);
    @(negedge clk);
    chk({nm, "_hit"}, {31'd0, hit}, {31'd0, eh});
    chk({nm, "_tgt"}, predictedTarget, et);
    cyc();
  endtask

  function automatic pc_t rpc();
    return pc_t'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
  endfunction

  task automatic rand_inputs();
    drive(rpc(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), rpc(), $urandom());
    if ($urandom_range(0, 4) == 0) updPc = fetchPc;
  endtask

  // Counts cycles with ready low after release; inject drives a taken update every INIT cycle.
  task automatic wait_ready(input string nm, input bit inject);
    int n;
    n = 0;
    while (n < 200) begin
      if (inject) drive(rpc(), 1'b1, 1'b1, 32'h0000_1040, 32'h0000_7000);
      else rand_inputs();
      @(negedge clk);
      if (ready) break;
      n++;
      cyc();
    end
    drive(32'h0000_1040, 1'b0, 1'b0, '0, '0);
    chk(nm, n, 64);
    cyc();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
    $fatal(1);
  end

  initial begin : main
    rst = 1'b0;
    cyc();
    chk_en = 1'b1;
    repeat (2) cyc();
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_hit", {31'd0, hit}, 32'd0);
    chk("rst_target", predictedTarget, 32'd0);

    rst = 1'b1;
    wait_ready("ready_latency", 1'b0);

    drive(32'h0000_1040, 1'b1, 1'b1, 32'h0000_1040, 32'h0000_2000);
    probe("install_same", 1'b0, 32'h0);
    drive(32'h0000_1040, 1'b0, 1'b0, '0, '0);
    probe("install_next", 1'b1, 32'h0000_2000);
    drive(32'h0000_1040, 1'b1, 1'b1, 32'h0000_2040, 32'h0000_3000);
    probe("alias_pre", 1'b1, 32'h0000_2000);
    drive(32'h0000_1040, 1'b0, 1'b0, '0, '0);
    probe("alias_old", 1'b0, 32'h0);
    drive(32'h0000_2040, 1'b0, 1'b0, '0, '0);
    probe("alias_new", 1'b1, 32'h0000_3000);
    drive(32'h0000_2040, 1'b1, 1'b0, 32'h0000_3040, '0);
    probe("nt_other_pre", 1'b1, 32'h0000_3000);
    drive(32'h0000_2040, 1'b0, 1'b0, '0, '0);
    probe("nt_other", 1'b1, 32'h0000_3000);
    drive(32'h0000_2040, 1'b1, 1'b0, 32'h0000_2040, '0);
    probe("nt_match_pre", 1'b1, 32'h0000_3000);
    drive(32'h0000_2040, 1'b0, 1'b0, '0, '0);
    probe("nt_match", 1'b0, 32'h0);
    drive(32'h0000_1080, 1'b1, 1'b1, 32'h0000_1080, 32'h0000_4444);
    probe("collide_same", 1'b0, 32'h0);
    drive(32'h0000_1080, 1'b0, 1'b0, '0, '0);
    probe("collide_next", 1'b1, 32'h0000_4444);
    drive(32'h0000_1082, 1'b1, 1'b1, 32'h0000_50C4, 32'h0000_5003);
    probe("pc_lowbits", 1'b1, 32'h0000_4444);
    drive(32'h0000_50C4, 1'b0, 1'b0, '0, '0);
    probe("tgt_lowbits", 1'b1, 32'h0000_5000);

    for (int k = 0; k < 1500; k++) begin
      rand_inputs();
      cyc();
    end

    // Reset from READY, then again part-way through the sweep.
    drive(32'h0000_1080, 1'b0, 1'b0, '0, '0);
    rst = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
    for (int k = 0; k < 30; k++) begin
      drive(rpc(), 1'b1, 1'b1, 32'h0000_1040, 32'h0000_7000);
      cyc();
    end
    rst = 1'b0;
    repeat (2) cyc();
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    rst = 1'b1;
    wait_ready("ready_latency_mid", 1'b1);
    drive(32'h0000_1040, 1'b0, 1'b0, '0, '0);
    probe("init_upd_ignored", 1'b0, 32'h0);

    for (int k = 0; k < 300; k++) begin
      rand_inputs();
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
